sd_arith_test_sequencer: RTL and testbench
==========================================

Name: sd_arith_test_sequencer

Overview:
- Sequential, parametrised self-checking stimulus engine for radix-2^LOG2_R signed-digit add/subtract units.
- Replaces fixed per-width test-vector tables with a small fixed set of corner vectors followed by LFSR-generated vectors.
- Drives x/y into the DUT, waits DUT_LATENCY cycles, then checks the DUT's z by numeric value, so any valid redundant encoding passes.
- Keeps pass/fail counts and records the first failure; sits in the arithmetic test harness between the DUT and the status readout.

Parameters:
- LOG2_R, 2: radix R = 2^LOG2_R. Digit width DW = LOG2_R+1, two's complement. Legal digit range is -(R-1)..R-1.
- N, 6: operand digit count. x and y are N*DW bits; z is (N+1)*DW bits.
- NUM_TESTS, 10: total vectors per run, minimum 3.
- DUT_LATENCY, 0: DUT pipeline depth in cycles.
- SEED, 32'h1: initial LFSR state. A SEED of 0 is replaced by 1.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  single-cycle pulse that begins a run; ignored while busy
- mode  in  1  1 = check x-y, 0 = check x+y; sampled on the start cycle
- x  out  N*DW  operand to DUT, registered
- y  out  N*DW  operand to DUT, registered
- z  in  (N+1)*DW  DUT result
- busy  out  1  high from the cycle after start until done
- done  out  1  level; set when a run ends, cleared by the next accepted start
- test_idx  out  16  index of the vector in flight
- pass_count  out  16  number of vectors that passed
- fail_count  out  16  number of vectors that failed
- first_fail_valid  out  1  a failure has been recorded this run
- first_fail_idx  out  16  index of the first failing vector

Behaviour:
- Reset (asynchronous): FSM goes to IDLE. All outputs are 0. LFSR loads SEED. Reset mid-run aborts the run with no residue.
- FSM states: IDLE -> GEN (N cycles) -> APPLY (1 cycle) -> WAIT (DUT_LATENCY cycles, skipped when 0) -> CHECK (1 cycle).
  - From CHECK, go to GEN if test_idx < NUM_TESTS-1, otherwise go to FINISH.
  - FINISH lasts 1 cycle, sets done, and returns to IDLE.
  - Cost per vector: N+2+DUT_LATENCY cycles.
- Accepted start: clears the counters, first_fail_*, done and test_idx, and latches mode. The LFSR is NOT reseeded, so successive runs use fresh vectors.
- LFSR: 32-bit Galois, right shift. If s[0]=1, the next state is (s>>1)^32'hA3000000; otherwise s>>1. It steps once per GEN cycle only.
- GEN, each cycle:
  - x digit = s[DW-1:0]; y digit = s[2DW-1:DW].
  - A digit equal to -R (1 followed by zeros) is mapped to 0.
  - Each new digit is shifted into the LSB end of internal staging registers, so the first generated digit ends up most significant.
- APPLY: x and y load from staging. Vectors 0, 1 and 2 are overridden regardless of staging:
  - vector 0: all digits 0
  - vector 1: all digits -(R-1)
  - vector 2: all digits +(R-1)
- x and y hold stable from APPLY through CHECK.
- Values:
  - val(v) = sum of d_i * R^i with signed digits, computed at width VW = LOG2_R*(N+1)+3.
  - ref = val(x) - val(y) if mode=1, otherwise val(x) + val(y).
- CHECK:
  - On the edge leaving CHECK, a vector passes if val(z) == ref.
  - Pass increments pass_count. Fail increments fail_count; on the first failure only, first_fail_idx = test_idx and first_fail_valid = 1.
  - test_idx increments when moving to GEN.
- Validity of z is not checked: digits equal to -R in z are evaluated numerically as-is.
- Counters saturate at 16'hFFFF.
- start in the same cycle as reset: reset wins.

Optional Feature:
- SD_TEST_STOP_ON_FAIL_EN defined: the first failing CHECK goes straight to FINISH. test_idx stays at the failing index and x/y stay at the failing operands, for debug.
- Not defined: every run completes all NUM_TESTS vectors.

Test Plan:
- Defaults, ideal combinational subtractor model, start with mode=1 -> busy for 80 cycles, then done=1, pass_count=10, fail_count=0, first_fail_valid=0.
- Defaults: sample x at APPLY of vectors 0, 1 and 2 -> 18'h0, 18'o555555, 18'o333333. The model's z evaluates to 0 for all three.
- Model returns correct value+1 only when test_idx==5 -> fail_count=1, pass_count=9, first_fail_idx=5, first_fail_valid=1.
- Model re-encodes its result's least significant digits, replacing (d1, d0=+1) with (d1+1, -3) whenever d1<3 -> pass_count=10.
- mode=0 adder model, DUT_LATENCY=3 pipelined model -> done after 110 cycles, pass_count=10. Also: reset pulsed at cycle 20 of a run -> all outputs 0 immediately; a following start completes normally.
- SD_TEST_STOP_ON_FAIL_EN defined, fault at idx 4 -> done asserted after the idx-4 CHECK, test_idx=4, pass_count=4, fail_count=1.

Source files
------------

// File: rtl/sd_arith_test_sequencer.sv
// Self-checking stimulus engine for radix-2^LOG2_R signed-digit add/subtract units.
// Optional macro SD_TEST_STOP_ON_FAIL_EN: end the run at the first failing vector.
module sd_arith_test_sequencer #(
    parameter int          LOG2_R      = 2,
    parameter int          N           = 6,
    parameter int          NUM_TESTS   = 10,
    parameter int          DUT_LATENCY = 0,
    parameter logic [31:0] SEED        = 32'h1
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               start,
    input  logic                               mode,
    output logic [N*(LOG2_R+1)-1:0]            x,
    output logic [N*(LOG2_R+1)-1:0]            y,
    input  logic [(N+1)*(LOG2_R+1)-1:0]        z,
    output logic                               busy,
    output logic                               done,
    output logic [15:0]                        test_idx,
    output logic [15:0]                        pass_count,
    output logic [15:0]                        fail_count,
    output logic                               first_fail_valid,
    output logic [15:0]                        first_fail_idx
);

    localparam int DW = LOG2_R + 1;
    localparam int XW = N * DW;
    localparam int ZW = (N + 1) * DW;
    localparam int VW = LOG2_R * (N + 1) + 3;
    localparam int R  = 1 << LOG2_R;

    localparam logic [31:0]   SEED_INIT = (SEED == 32'h0) ? 32'h1 : SEED;
    localparam logic [31:0]   LFSR_TAPS = 32'hA3000000;
    localparam logic [DW-1:0] DIG_MAX   = DW'(R - 1);
    localparam logic [DW-1:0] DIG_MIN   = DW'(R + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GEN,
        S_APPLY,
        S_WAIT,
        S_CHECK,
        S_FINISH
    } state_t;

    state_t        state;
    logic [31:0]   lfsr;
    logic [XW-1:0] stage_x;
    logic [XW-1:0] stage_y;
    logic [15:0]   gen_cnt;
    logic [15:0]   wait_cnt;
    logic          mode_q;

    // -R is not a legal digit, so it is folded to zero before staging.
    function automatic logic [DW-1:0] clip_digit(input logic [DW-1:0] d);
        return (d == {1'b1, {(DW-1){1'b0}}}) ? '0 : d;
    endfunction

    // Numeric value of a signed-digit word, Horner form from the top digit down.
    function automatic logic [VW-1:0] sd_val(input logic [ZW-1:0] v);
        logic [VW-1:0] acc;
        logic [DW-1:0] d;
        acc = '0;
        for (int i = N; i >= 0; i--) begin
            d   = v[i*DW +: DW];
            acc = (acc << LOG2_R) + {{(VW-DW){d[DW-1]}}, d};
        end
        return acc;
    endfunction

    logic [31:0]      lfsr_nxt;
    logic [XW+DW-1:0] shift_x;
    logic [XW+DW-1:0] shift_y;
    logic [XW-1:0]    stage_x_nxt;
    logic [XW-1:0]    stage_y_nxt;
    logic [VW-1:0]    val_x;
    logic [VW-1:0]    val_y;
    logic [VW-1:0]    ref_val;
    logic             z_ok;
    logic             last_vec;
    logic             stop_now;

    assign lfsr_nxt    = lfsr[0] ? ((lfsr >> 1) ^ LFSR_TAPS) : (lfsr >> 1);
    assign shift_x     = {stage_x, clip_digit(lfsr[DW-1:0])};
    assign shift_y     = {stage_y, clip_digit(lfsr[2*DW-1:DW])};
    assign stage_x_nxt = shift_x[XW-1:0];
    assign stage_y_nxt = shift_y[XW-1:0];

    assign val_x    = sd_val({{DW{1'b0}}, x});
    assign val_y    = sd_val({{DW{1'b0}}, y});
    assign ref_val  = mode_q ? (val_x - val_y) : (val_x + val_y);
    assign z_ok     = (sd_val(z) == ref_val);
    assign last_vec = (test_idx >= 16'(NUM_TESTS - 1));

`ifdef SD_TEST_STOP_ON_FAIL_EN
    assign stop_now = last_vec || !z_ok;
`else
    assign stop_now = last_vec;
`endif

    // start is a one-cycle request honoured only in IDLE; busy rises the next
    // cycle and falls together with the rise of done, which is a held level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= S_IDLE;
            lfsr             <= SEED_INIT;
            stage_x          <= '0;
            stage_y          <= '0;
            gen_cnt          <= '0;
            wait_cnt         <= '0;
            mode_q           <= 1'b0;
            x                <= '0;
            y                <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            test_idx         <= '0;
            pass_count       <= '0;
            fail_count       <= '0;
            first_fail_valid <= 1'b0;
            first_fail_idx   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        mode_q           <= mode;
                        busy             <= 1'b1;
                        done             <= 1'b0;
                        test_idx         <= '0;
                        pass_count       <= '0;
                        fail_count       <= '0;
                        first_fail_valid <= 1'b0;
                        first_fail_idx   <= '0;
                        gen_cnt          <= '0;
                        state            <= S_GEN;
                    end
                end
                S_GEN: begin
                    lfsr    <= lfsr_nxt;
                    stage_x <= stage_x_nxt;
                    stage_y <= stage_y_nxt;
                    gen_cnt <= gen_cnt + 16'd1;
                    if (gen_cnt == 16'(N - 1)) begin
                        gen_cnt <= '0;
                        state   <= S_APPLY;
                        // The first three vectors are fixed corner cases.
                        if (test_idx == 16'd0) begin
                            x <= '0;
                            y <= '0;
                        end else if (test_idx == 16'd1) begin
                            x <= {N{DIG_MIN}};
                            y <= {N{DIG_MIN}};
                        end else if (test_idx == 16'd2) begin
                            x <= {N{DIG_MAX}};
                            y <= {N{DIG_MAX}};
                        end else begin
                            x <= stage_x_nxt;
                            y <= stage_y_nxt;
                        end
                    end
                end
                S_APPLY: begin
                    wait_cnt <= '0;
                    state    <= (DUT_LATENCY == 0) ? S_CHECK : S_WAIT;
                end
                S_WAIT: begin
                    wait_cnt <= wait_cnt + 16'd1;
                    if (wait_cnt == 16'(DUT_LATENCY - 1)) begin
                        state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (z_ok) begin
                        if (pass_count != 16'hFFFF) pass_count <= pass_count + 16'd1;
                    end else begin
                        if (fail_count != 16'hFFFF) fail_count <= fail_count + 16'd1;
                        if (!first_fail_valid) begin
                            first_fail_valid <= 1'b1;
                            first_fail_idx   <= test_idx;
                        end
                    end
                    if (stop_now) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_FINISH;
                    end else begin
                        test_idx <= test_idx + 16'd1;
                        state    <= S_GEN;
                    end
                end
                S_FINISH: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sd_arith_test_sequencer.sv
// Bench for sd_arith_test_sequencer: one combinational and one 3-stage pipelined
// signed-digit add/sub model, table-driven runs plus reset-abort sequence.
module tb_sd_arith_test_sequencer;

    localparam int          LOG2_R = 2;
    localparam int          N      = 6;
    localparam int          NUM    = 10;
    localparam int          R      = 1 << LOG2_R;
    localparam int          DW     = LOG2_R + 1;
    localparam int          XW     = N * DW;
    localparam int          ZW     = (N + 1) * DW;
    localparam logic [31:0] SEED   = 32'h1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst[2];
    logic          start[2];
    logic          mode[2];
    logic [XW-1:0] xs[2];
    logic [XW-1:0] ys[2];
    logic [ZW-1:0] zs[2];
    logic          busy[2];
    logic          done[2];
    logic          ffv[2];
    logic [15:0]   tidx[2];
    logic [15:0]   pc[2];
    logic [15:0]   fc[2];
    logic [15:0]   ffi[2];

    // Model controls: fault kind 0 none, 1 result+1 at index fi, 2 low-digit re-encode.
    int          fk[2];
    int          fi[2];
    logic        mm[2];
    logic [31:0] lfsr_m[2];
    int          lat[2] = '{0, 3};

    int checks   = 0;
    int failures = 0;

    logic [XW-1:0] exp_q[$];

    sd_arith_test_sequencer #(.LOG2_R(LOG2_R), .N(N), .NUM_TESTS(NUM), .DUT_LATENCY(0), .SEED(SEED)) u_dut0 (
        .clk(clk), .reset(rst[0]), .start(start[0]), .mode(mode[0]),
        .x(xs[0]), .y(ys[0]), .z(zs[0]), .busy(busy[0]), .done(done[0]),
        .test_idx(tidx[0]), .pass_count(pc[0]), .fail_count(fc[0]),
        .first_fail_valid(ffv[0]), .first_fail_idx(ffi[0])
    );

    sd_arith_test_sequencer #(.LOG2_R(LOG2_R), .N(N), .NUM_TESTS(NUM), .DUT_LATENCY(3), .SEED(SEED)) u_dut3 (
        .clk(clk), .reset(rst[1]), .start(start[1]), .mode(mode[1]),
        .x(xs[1]), .y(ys[1]), .z(zs[1]), .busy(busy[1]), .done(done[1]),
        .test_idx(tidx[1]), .pass_count(pc[1]), .fail_count(fc[1]),
        .first_fail_valid(ffv[1]), .first_fail_idx(ffi[1])
    );

    // ---------------- reference arithmetic ----------------
    function automatic int sd_val(input logic [ZW-1:0] v, input int nd);
        int s;
        int d;
        logic [DW-1:0] t;
        s = 0;
        for (int i = 0; i < nd; i++) begin
            t = v[i*DW +: DW];
            d = int'(t);
            if (t[DW-1]) d = d - 2 * R;
            s = s + d * (1 << (LOG2_R * i));
        end
        return s;
    endfunction

    function automatic logic [ZW-1:0] model_z(input logic [XW-1:0] a, input logic [XW-1:0] b,
                                              input logic m, input int kind, input logic hit);
        int r;
        int d;
        int digs[N+1];
        logic [ZW-1:0] zz;
        r = m ? sd_val({{DW{1'b0}}, a}, N) - sd_val({{DW{1'b0}}, b}, N)
              : sd_val({{DW{1'b0}}, a}, N) + sd_val({{DW{1'b0}}, b}, N);
        if (kind == 1 && hit) r = r + 1;
        for (int i = 0; i < N; i++) begin
            d       = ((r % R) + R) % R;
            digs[i] = d;
            r       = (r - d) / R;
        end
        digs[N] = r;
        if (kind == 2 && digs[0] == 1 && digs[1] < 3) begin
            digs[1] = digs[1] + 1;
            digs[0] = -3;
        end
        zz = '0;
        for (int i = 0; i <= N; i++) zz[i*DW +: DW] = DW'(digs[i]);
        return zz;
    endfunction

    logic [ZW-1:0] zc1, p1, p2, p3;
    assign zs[0] = model_z(xs[0], ys[0], mm[0], fk[0], tidx[0] == 16'(fi[0]));
    assign zc1   = model_z(xs[1], ys[1], mm[1], fk[1], tidx[1] == 16'(fi[1]));
    always @(posedge clk) begin
        p1 <= zc1;
        p2 <= p1;
        p3 <= p2;
    end
    assign zs[1] = p3;

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string name, input longint act, input longint expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
        end
    endtask

    // Expected operands of the next nvec vectors, from the LFSR rule.
    task automatic gen_expected(input int u, input int nvec);
        logic [XW-1:0] ex, ey;
        logic [DW-1:0] dx, dy;
        logic [31:0]   s;
        s = lfsr_m[u];
        for (int v = 0; v < nvec; v++) begin
            ex = '0;
            ey = '0;
            for (int j = 0; j < N; j++) begin
                dx = s[DW-1:0];
                dy = s[2*DW-1:DW];
                if (dx == DW'(R)) dx = '0;
                if (dy == DW'(R)) dy = '0;
                ex = ex | (XW'(dx) << (DW * (N - 1 - j)));
                ey = ey | (XW'(dy) << (DW * (N - 1 - j)));
                s  = s[0] ? ((s >> 1) ^ 32'hA3000000) : (s >> 1);
            end
            if (v == 0) begin
                ex = '0;
                ey = '0;
            end else if (v == 1 || v == 2) begin
                for (int j = 0; j < N; j++) begin
                    ex[j*DW +: DW] = (v == 1) ? DW'(R + 1) : DW'(R - 1);
                    ey[j*DW +: DW] = (v == 1) ? DW'(R + 1) : DW'(R - 1);
                end
            end
            exp_q.push_back(ex);
            exp_q.push_back(ey);
        end
        lfsr_m[u] = s;
    endtask

    task automatic check_zero(input int u, input string tag);
        check({tag, "_xy"}, {xs[u], ys[u]}, 0);
        check({tag, "_flags"}, {busy[u], done[u], ffv[u]}, 0);
        check({tag, "_counts"}, {tidx[u], pc[u], fc[u], ffi[u]}, 0);
    endtask

    // ---------------- driver / run task ----------------
    task automatic run(input int u, input logic m, input int kind, input int fidx, input int nvec,
                       input int ep, input int ef, input int effv, input int effi, input int etidx,
                       input int abort_at, input bit poke);
        int            p, done_k, first_done, busy_bad, v;
        logic [XW-1:0] ex, ey, last_x;
        bit            poked;
        p          = N + 2 + lat[u];
        done_k     = nvec * p;
        first_done = -1;
        busy_bad   = 0;
        poked      = 0;
        last_x     = '0;
        fk[u]      = kind;
        fi[u]      = fidx;
        mm[u]      = m;
        exp_q.delete();
        gen_expected(u, nvec);
        repeat ($urandom_range(0, 4)) @(negedge clk);
        @(negedge clk);
        start[u] = 1'b1;
        mode[u]  = m;
        @(posedge clk);
        #1;
        start[u] = 1'b0;
        mode[u]  = ~m;
        for (int k = 0; k <= done_k + 20; k++) begin
            @(negedge clk);
            if (poked) begin
                start[u] = 1'b0;
                poked    = 0;
            end
            if (k == abort_at) begin
                rst[u] = 1'b1;
                #1;
                check_zero(u, "abort");
                @(negedge clk);
                rst[u]    = 1'b0;
                lfsr_m[u] = SEED;
                exp_q.delete();
                return;
            end
            if (done[u]) begin
                first_done = k;
                break;
            end
            if (!busy[u]) busy_bad++;
            v = k / p;
            if (k % p == N && v < nvec && exp_q.size() >= 2) begin
                ex     = exp_q.pop_front();
                ey     = exp_q.pop_front();
                last_x = ex;
                check("apply_x", xs[u], ex);
                check("apply_y", ys[u], ey);
                check("apply_idx", tidx[u], v);
                if (lat[u] == 0 && kind == 0 && m && v < 3)
                    check("corner_z_val", sd_val(zs[u], N + 1), 0);
                if (poke && v == 3) begin
                    start[u] = 1'b1;
                    poked    = 1;
                end
            end
        end
        check("done_cycle", first_done, done_k);
        check("busy_early", busy_bad, 0);
        check("queue_left", exp_q.size(), 0);
        if (first_done >= 0) begin
            check("busy_at_done", busy[u], 0);
            check("pass_count", pc[u], ep);
            check("fail_count", fc[u], ef);
            check("ff_valid", ffv[u], effv);
            check("ff_idx", ffi[u], effi);
            check("test_idx", tidx[u], etidx);
            check("x_held", xs[u], last_x);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic m;
        int   kind;
        int   fidx;
        int   ep;
        int   ef;
        int   effv;
        int   effi;
        int   etidx;
        int   nvec;
    } vec_t;

    function automatic vec_t mk(input logic m, input int kind, input int fidx, input int ep, input int ef,
                                input int effv, input int effi, input int etidx, input int nvec);
        vec_t t;
        t.m = m; t.kind = kind; t.fidx = fidx; t.ep = ep; t.ef = ef;
        t.effv = effv; t.effi = effi; t.etidx = etidx; t.nvec = nvec;
        return t;
    endfunction

    vec_t tbl[8];

    initial begin
        tbl[0] = mk(1'b1, 0, 0, 10, 0, 0, 0, 9, 10);
        tbl[2] = mk(1'b1, 2, 0, 10, 0, 0, 0, 9, 10);
        tbl[3] = mk(1'b0, 0, 0, 10, 0, 0, 0, 9, 10);
        tbl[7] = mk(1'($urandom_range(0, 1)), 2, 0, 10, 0, 0, 0, 9, 10);
`ifdef SD_TEST_STOP_ON_FAIL_EN
        tbl[1] = mk(1'b1, 1, 5, 5, 1, 1, 5, 5, 6);
        tbl[4] = mk(1'b0, 1, 4, 4, 1, 1, 4, 4, 5);
        tbl[5] = mk(1'($urandom_range(0, 1)), 1, 0, 0, 1, 1, 0, 0, 1);
        tbl[6] = mk(1'($urandom_range(0, 1)), 1, 9, 9, 1, 1, 9, 9, 10);
`else
        tbl[1] = mk(1'b1, 1, 5, 9, 1, 1, 5, 9, 10);
        tbl[4] = mk(1'b0, 1, 4, 9, 1, 1, 4, 9, 10);
        tbl[5] = mk(1'($urandom_range(0, 1)), 1, 0, 9, 1, 1, 0, 9, 10);
        tbl[6] = mk(1'($urandom_range(0, 1)), 1, 9, 9, 1, 1, 9, 9, 10);
`endif

        rst    = '{1'b1, 1'b1};
        start  = '{1'b0, 1'b0};
        mode   = '{1'b0, 1'b0};
        mm     = '{1'b0, 1'b0};
        fk     = '{0, 0};
        fi     = '{0, 0};
        lfsr_m = '{SEED, SEED};
        repeat (2) @(negedge clk);
        check_zero(0, "reset0");
        check_zero(1, "reset3");
        rst = '{1'b0, 1'b0};
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            run(0, tbl[i].m, tbl[i].kind, tbl[i].fidx, tbl[i].nvec, tbl[i].ep, tbl[i].ef,
                tbl[i].effv, tbl[i].effi, tbl[i].etidx, -1, i == 0);
        end

        run(1, 1'b0, 0, 0, 10, 10, 0, 0, 0, 9, -1, 0);
        run(1, 1'b0, 0, 0, 10, 10, 0, 0, 0, 9, 20, 0);
        run(1, 1'($urandom_range(0, 1)), 0, 0, 10, 10, 0, 0, 0, 9, -1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
